ifetch_ir: RTL and testbench

Instruction-fetch and instruction-register stage of the multi-cycle CPU. On a fetch command from the control unit, it issues a word read at the current PC and waits for the memory acknowledge. It then latches the returned word into the instruction register and advances the PC. The register's fixed fields are sliced out for downstream use; `imm_16` feeds the 16→32 sign extender and the `rs`/`rt`/`rd` fields feed the register file.

---
 rtl/ifetch_ir_if.sv | 26 ++
 rtl/ifetch_ir.sv | 150 +++++++++++++++
 tb/tb_ifetch_ir.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_ir_if.sv
// ifetch_ir_if: instruction-memory read bus between the fetch stage and memory.
//   mem_req   : read request (fetch side drives, registered)
//   mem_addr  : word address, valid while mem_req=1
//   mem_ack   : read data valid, only meaningful while mem_req=1
//   mem_rdata : returned instruction word
// master = fetch stage, slave = memory.
interface ifetch_ir_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ifetch_ir.sv
// ifetch_ir: instruction-fetch / instruction-register stage of the multi-cycle CPU.
// A fetch_start issues a word read at the current PC, waits for mem_ack,
// latches the word into ir and advances the PC (or applies a branch captured
// while the read was outstanding).  Fixed instruction fields are sliced from ir.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   fetch_start           : one-cycle fetch command
//   pc_we, pc_next        : PC load (branch/jump)
//   bus                   : instruction-memory read bus (master side)
//   ir, ir_valid          : instruction register and its sticky valid flag
//   fetch_done            : one-cycle pulse while the new ir is first visible
//   busy                  : high in REQ and DONE
//   fault                 : sticky misaligned-PC flag
//   pc, pc_plus4          : current PC and PC+4
//   opcode..j_target      : instruction fields, combinational from ir
module ifetch_ir #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  ifetch_ir_if.master bus,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_done,
  output logic        busy,
  output logic        fault,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm_16,
  output logic [25:0] j_target
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        ir_valid_q;
  logic        mem_req_q;
  logic        fetch_done_q;
  logic        busy_q;
  logic        fault_q;
  logic        pend_q;
  logic [31:0] pend_pc_q;

  logic [31:0] fetch_pc_d;
  logic [31:0] pc_plus4_d;

  // A same-cycle PC load redirects the fetch in IDLE.
  assign fetch_pc_d = pc_we ? pc_next : pc_q;
  assign pc_plus4_d = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 32'h0;
      ir_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_pc_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pc_we) pc_q <= pc_next;
          if (fetch_start) begin
            if (fetch_pc_d[1:0] == 2'b00) begin
              state_q   <= S_REQ;
              mem_req_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            state_q      <= S_DONE;
            mem_req_q    <= 1'b0;
            fetch_done_q <= 1'b1;
            ir_q         <= bus.mem_rdata;
            ir_valid_q   <= 1'b1;
            pend_q       <= 1'b0;
            // A PC write on the ack edge is the newest one, so it wins.
            if (pc_we)       pc_q <= pc_next;
            else if (pend_q) pc_q <= pend_pc_q;
            else             pc_q <= pc_plus4_d;
          end else if (pc_we) begin
            // PC must stay put while mem_addr is in use; defer the load.
            pend_q    <= 1'b1;
            pend_pc_q <= pc_next;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          fetch_done_q <= 1'b0;
          busy_q       <= 1'b0;
          if (pc_we) pc_q <= pc_next;
        end
        default: begin // S_FAULT: only an aligned PC load recovers
          if (pc_we && (pc_next[1:0] == 2'b00)) begin
            state_q <= S_IDLE;
            pc_q    <= pc_next;
            fault_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // PC is frozen during REQ, so the PC register doubles as the read address.
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc_q;

  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_done = fetch_done_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_d;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_16   = ir_q[15:0];
  assign j_target = ir_q[25:0];

endmodule

// File: tb/tb_ifetch_ir.sv
// tb_ifetch_ir: scoreboard bench for ifetch_ir.  Each fetch pushes its
// hand-computed expectation; a monitor pops and compares on fetch_done.
module tb_ifetch_ir;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_we = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] ir, pc, pc_plus4;
  logic        ir_valid, fetch_done, busy, fault;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm_16;
  logic [25:0] j_target;

  ifetch_ir_if bus_if ();

  ifetch_ir #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start),
    .pc_we(pc_we), .pc_next(pc_next), .bus(bus_if.master),
    .ir(ir), .ir_valid(ir_valid), .fetch_done(fetch_done), .busy(busy),
    .fault(fault), .pc(pc), .pc_plus4(pc_plus4), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_16(imm_16), .j_target(j_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pc;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          req_cycles = 0;
  bit          busy_bad = 0;
  logic [31:0] req_addr = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      req_cycles = 0;
      busy_bad   = 0;
    end else begin
      if (bus_if.mem_req) begin
        if (req_cycles == 0) req_addr = bus_if.mem_addr;
        req_cycles++;
        if (!busy) busy_bad = 1;
      end
      if (fetch_done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch_done: got ir=%h pc=%h expected no completion", ir, pc);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", {42'h0, req_addr}, {42'h0, e.addr});
          chk("ir", {42'h0, ir}, {42'h0, e.ir});
          chk("pc", {42'h0, pc}, {42'h0, e.pc});
          chk("ir_valid", {73'h0, ir_valid}, 74'h1);
          chk("req_cycles", 74'(req_cycles), 74'(e.waits + 1));
          chk("busy_in_req", {73'h0, busy_bad}, 74'h0);
          chk("fields", {opcode, rs, rt, rd, shamt, funct, imm_16, j_target},
              {e.ir[31:26], e.ir[25:21], e.ir[20:16], e.ir[15:11],
               e.ir[10:6], e.ir[5:0], e.ir[15:0], e.ir[25:0]});
        end
        req_cycles = 0;
        busy_bad   = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch: optional same-cycle PC load, optional branch at wait cycle
  // branch_at, then ack after 'waits' wait cycles.
  task automatic fetch(input logic [31:0] rdata, input int waits,
                       input bit start_we, input logic [31:0] start_pc,
                       input int branch_at, input logic [31:0] branch_pc,
                       input logic [31:0] exp_addr, input logic [31:0] exp_pc);
    exp_t e;
    e.addr = exp_addr; e.ir = rdata; e.pc = exp_pc; e.waits = waits;
    exp_q.push_back(e);
    $display("fetch: rdata=%h waits=%0d exp_addr=%h exp_pc=%h", rdata, waits, exp_addr, exp_pc);
    fetch_start = 1'b1;
    pc_we = start_we;
    pc_next = start_pc;
    tick();
    fetch_start = 1'b0;
    pc_we = 1'b0;
    for (int i = 0; i < waits; i++) begin
      bus_if.mem_ack = 1'b0;
      if (i == branch_at) begin
        pc_we = 1'b1;
        pc_next = branch_pc;
      end
      tick();
      pc_we = 1'b0;
    end
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = rdata;
    tick();
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = 32'hDEAD_BEEF;
    tick();
  endtask

  initial begin
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_pc", {42'h0, pc}, 74'h0);
    chk("rst_ir", {42'h0, ir}, 74'h0);
    chk("rst_flags", {68'h0, ir_valid, bus_if.mem_req, fetch_done, fault, busy, 1'b0}, 74'h0);
    @(posedge clk); #1;

    // Basic fetch, zero wait
    fetch(32'h2008_FFFF, 0, 0, 32'h0, -1, 32'h0, 32'h0000_0000, 32'h0000_0004);
    // Wait states
    fetch(32'h8C22_0004, 3, 0, 32'h0, -1, 32'h0, 32'h0000_0004, 32'h0000_0008);
    // Branch at the 2nd wait cycle
    fetch(32'h1000_0003, 3, 0, 32'h0, 1, 32'h0000_0100, 32'h0000_0008, 32'h0000_0100);
    // Next fetch uses the branch target
    fetch(32'h012A_4020, 1, 0, 32'h0, -1, 32'h0, 32'h0000_0100, 32'h0000_0104);
    // Same-cycle pc_we + fetch_start
    fetch(32'h0800_0010, 0, 1, 32'h0000_0040, -1, 32'h0, 32'h0000_0040, 32'h0000_0044);

    // Misaligned fetch
    $display("misalign: pc_we=00000102 with fetch_start");
    pc_we = 1'b1; pc_next = 32'h0000_0102; fetch_start = 1'b1;
    tick();
    pc_we = 1'b0; fetch_start = 1'b0;
    @(negedge clk);
    chk("fault_set", {72'h0, fault, bus_if.mem_req}, 74'h2);
    @(posedge clk); #1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    @(negedge clk);
    chk("fault_ignore_start", {71'h0, fault, bus_if.mem_req, busy}, 74'h4);
    @(posedge clk); #1;
    $display("recover: pc_we=00000200");
    pc_we = 1'b1; pc_next = 32'h0000_0200;
    tick();
    pc_we = 1'b0;
    @(negedge clk);
    chk("fault_clear", {71'h0, fault, bus_if.mem_req, busy}, 74'h0);
    chk("fault_pc", {42'h0, pc}, {42'h0, 32'h0000_0200});
    chk("ir_hold", {42'h0, ir}, {42'h0, 32'h0800_0010});
    @(posedge clk); #1;

    // Wrap at top of address space
    fetch(32'h3C01_1234, 0, 1, 32'hFFFF_FFFC, -1, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_no_fault", {73'h0, fault}, 74'h0);
    @(posedge clk); #1;

    // Reset mid-REQ
    $display("reset mid-REQ");
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", {72'h0, bus_if.mem_req, busy}, 74'h0);
    chk("rst_async_ir", {42'h0, ir}, 74'h0);
    chk("rst_async_pc", {42'h0, pc}, 74'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = 32'hAAAA_5555;
    repeat (2) @(posedge clk);
    #1 bus_if.mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ir", {41'h0, ir_valid, ir}, 74'h0);
    chk("late_ack_pc", {42'h0, pc}, 74'h0);
    chk("late_ack_req", {73'h0, bus_if.mem_req}, 74'h0);

    // Scoreboard drained, exact number of completions
    repeat (2) @(negedge clk);
    chk("sb_empty", 74'(exp_q.size()), 74'h0);
    chk("done_count", 74'(done_count), 74'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
